// File: rtl/conv1_lbuf_pkg.sv
// Shared constants and state type for the conv1 -> max-pool line buffer.
package conv1_lbuf_pkg;

  localparam int NUM_FILT_DEF       = 6;
  localparam int OPERAND_WDTH_DEF   = 22;
  localparam int NUM_PIXELS_BUF_DEF = 4;
  localparam int ROW_WDTH_DEF       = 28;
  localparam int NUM_ROWS_DEF       = 28;
  localparam int BEATS_PER_ROW      = ROW_WDTH_DEF / NUM_PIXELS_BUF_DEF;

  typedef enum logic {
    FILL = 1'b0,
    PAIR = 1'b1
  } lbuf_state_t;

endpackage

// File: rtl/conv1_pool_line_buf_if.sv
// Beat stream in from conv1 and row-pair stream out to the max-pool.
interface conv1_pool_line_buf_if #(
  parameter int NUM_FILT       = conv1_lbuf_pkg::NUM_FILT_DEF,
  parameter int NUM_PIXELS_BUF = conv1_lbuf_pkg::NUM_PIXELS_BUF_DEF,
  parameter int OPERAND_WDTH   = conv1_lbuf_pkg::OPERAND_WDTH_DEF
);

  logic                                                        conv1_lbuf_vld_i;
  logic                                                        conv1_lbuf_rdy_o;
  logic [NUM_FILT-1:0][NUM_PIXELS_BUF-1:0][OPERAND_WDTH-1:0]   conv1_lbuf_pix_i;
  logic [NUM_FILT-1:0][NUM_PIXELS_BUF-1:0][OPERAND_WDTH-1:0]   conv1_lbuf_a_o;
  logic [NUM_FILT-1:0][NUM_PIXELS_BUF-1:0][OPERAND_WDTH-1:0]   conv1_lbuf_b_o;
  logic                                                        conv1_lbuf_vld_o;
  logic                                                        conv1_lbuf_rdy_i;
  logic                                                        conv1_lbuf_frame_done_o;

  modport master (
    output conv1_lbuf_vld_i, conv1_lbuf_pix_i, conv1_lbuf_rdy_i,
    input  conv1_lbuf_rdy_o, conv1_lbuf_a_o, conv1_lbuf_b_o,
           conv1_lbuf_vld_o, conv1_lbuf_frame_done_o
  );

  modport slave (
    input  conv1_lbuf_vld_i, conv1_lbuf_pix_i, conv1_lbuf_rdy_i,
    output conv1_lbuf_rdy_o, conv1_lbuf_a_o, conv1_lbuf_b_o,
           conv1_lbuf_vld_o, conv1_lbuf_frame_done_o
  );

endinterface

// File: rtl/conv1_lbuf_row_mem.sv
// One-row beat store: single write port, asynchronous read.
// Latency: write visible the cycle after we; read is combinational.
// Backpressure: none, the owner sequences reads and writes.
module conv1_lbuf_row_mem #(
  parameter int DEPTH = conv1_lbuf_pkg::BEATS_PER_ROW,
  parameter int AW    = 3,
  parameter int DW    = 528
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdat,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdat
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdat;
  end

  assign rdat = mem[raddr];

endmodule

// File: rtl/conv1_pool_line_buf.sv
// Buffers an even conv1 row and pairs it with the following odd row for 2x2 max-pool.
// Latency: 1 cycle from odd-row accept to vld_o; even rows produce no output.
// Backpressure: even rows always ready; odd rows ready only when output is free. Optional CONV1_LBUF_RELU_EN.
module conv1_pool_line_buf
  import conv1_lbuf_pkg::*;
#(
  parameter int NUM_FILT       = NUM_FILT_DEF,
  parameter int OPERAND_WDTH   = OPERAND_WDTH_DEF,
  parameter int NUM_PIXELS_BUF = NUM_PIXELS_BUF_DEF,
  parameter int ROW_WDTH       = ROW_WDTH_DEF,
  parameter int NUM_ROWS       = NUM_ROWS_DEF
) (
  input  logic                    conv1_lbuf_clk,
  input  logic                    conv1_lbuf_rst_b,
  conv1_pool_line_buf_if.slave    lbuf
);

  localparam int BEATS = ROW_WDTH / NUM_PIXELS_BUF;
  localparam int COL_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int ROW_W = $clog2(NUM_ROWS);
  localparam int PIX_W = NUM_FILT * NUM_PIXELS_BUF * OPERAND_WDTH;

  typedef logic [NUM_FILT-1:0][NUM_PIXELS_BUF-1:0][OPERAND_WDTH-1:0] pix_t;

  lbuf_state_t      state_q;
  logic [COL_W-1:0] col_cnt, col_nxt;
  logic [ROW_W-1:0] row_cnt, row_nxt;
  pix_t             a_q, b_q, pix_c, rd_dat;
  logic             vld_q, last_q, done_q;
  logic             rdy, accept, consume, col_last, row_last;

  assign rdy      = (state_q == FILL) || !vld_q || lbuf.conv1_lbuf_rdy_i;
  assign accept   = lbuf.conv1_lbuf_vld_i && rdy;
  assign consume  = vld_q && lbuf.conv1_lbuf_rdy_i;
  assign col_last = (col_cnt == COL_W'(BEATS - 1));
  assign row_last = (row_cnt == ROW_W'(NUM_ROWS - 1));

  always_comb begin
    pix_c = lbuf.conv1_lbuf_pix_i;
`ifdef CONV1_LBUF_RELU_EN
    for (int f = 0; f < NUM_FILT; f++) begin
      for (int p = 0; p < NUM_PIXELS_BUF; p++) begin
        if (pix_c[f][p][OPERAND_WDTH-1]) pix_c[f][p] = '0;
      end
    end
`endif
  end

  always_comb begin
    col_nxt = col_cnt + COL_W'(1);
    row_nxt = row_cnt;
    if (col_last) begin
      col_nxt = '0;
      row_nxt = row_last ? '0 : row_cnt + ROW_W'(1);
    end
  end

  conv1_lbuf_row_mem #(
    .DEPTH (BEATS),
    .AW    (COL_W),
    .DW    (PIX_W)
  ) u_row_mem (
    .clk   (conv1_lbuf_clk),
    .we    (accept && (state_q == FILL)),
    .waddr (col_cnt),
    .wdat  (pix_c),
    .raddr (col_cnt),
    .rdat  (rd_dat)
  );

  // last_q marks the pending pair as the frame's final one so done fires on its consume.
  always_ff @(posedge conv1_lbuf_clk or negedge conv1_lbuf_rst_b) begin
    if (!conv1_lbuf_rst_b) begin
      state_q <= FILL;
      col_cnt <= '0;
      row_cnt <= '0;
      a_q     <= '0;
      b_q     <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= consume && last_q;
      if (accept) begin
        col_cnt <= col_nxt;
        row_cnt <= row_nxt;
        state_q <= row_nxt[0] ? PAIR : FILL;
      end
      if (accept && (state_q == PAIR)) begin
        a_q    <= rd_dat;
        b_q    <= pix_c;
        vld_q  <= 1'b1;
        last_q <= row_last && col_last;
      end else if (consume) begin
        vld_q  <= 1'b0;
        last_q <= 1'b0;
      end
    end
  end

  assign lbuf.conv1_lbuf_rdy_o        = rdy;
  assign lbuf.conv1_lbuf_a_o          = a_q;
  assign lbuf.conv1_lbuf_b_o          = b_q;
  assign lbuf.conv1_lbuf_vld_o        = vld_q;
  assign lbuf.conv1_lbuf_frame_done_o = done_q;

endmodule

// File: tb/tb_conv1_pool_line_buf.sv
// Directed bench for conv1_pool_line_buf; honours CONV1_LBUF_RELU_EN when defined.
module tb_conv1_pool_line_buf;
  import conv1_lbuf_pkg::*;

  localparam int NF  = NUM_FILT_DEF;
  localparam int NP  = NUM_PIXELS_BUF_DEF;
  localparam int OW  = OPERAND_WDTH_DEF;
  localparam int BPR = BEATS_PER_ROW;
  localparam int NR  = NUM_ROWS_DEF;

  typedef logic [NF-1:0][NP-1:0][OW-1:0] pix_t;

  logic clk   = 1'b0;
  logic rst_b = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  conv1_pool_line_buf_if #(.NUM_FILT(NF), .NUM_PIXELS_BUF(NP), .OPERAND_WDTH(OW)) lbuf ();

  conv1_pool_line_buf #(
    .NUM_FILT       (NF),
    .OPERAND_WDTH   (OW),
    .NUM_PIXELS_BUF (NP),
    .ROW_WDTH       (ROW_WDTH_DEF),
    .NUM_ROWS       (NR)
  ) dut (
    .conv1_lbuf_clk   (clk),
    .conv1_lbuf_rst_b (rst_b),
    .lbuf             (lbuf)
  );

  function automatic pix_t fill(int v);
    pix_t p;
    for (int f = 0; f < NF; f++)
      for (int q = 0; q < NP; q++)
        p[f][q] = OW'(v);
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one beat and returns 1 ns after the edge that accepted it.
  task automatic send(int v);
    int n;
    n = 0;
    lbuf.conv1_lbuf_pix_i = fill(v);
    lbuf.conv1_lbuf_vld_i = 1'b1;
    #1;
    while (lbuf.conv1_lbuf_rdy_o !== 1'b1 && n < 50) begin
      tick();
      #1;
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL send_timeout value=%0d rdy_o=%b required 1", v, lbuf.conv1_lbuf_rdy_o);
    end
    @(posedge clk);
    #1;
    lbuf.conv1_lbuf_vld_i = 1'b0;
  endtask

  task automatic do_reset();
    lbuf.conv1_lbuf_vld_i = 1'b0;
    lbuf.conv1_lbuf_rdy_i = 1'b1;
    lbuf.conv1_lbuf_pix_i = '0;
    rst_b = 1'b0;
    tick();
    rst_b = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    lbuf.conv1_lbuf_vld_i = 1'b0;
    lbuf.conv1_lbuf_rdy_i = 1'b1;
    lbuf.conv1_lbuf_pix_i = '0;
    rst_b = 1'b0;
    #2;
    checks++;
    if (lbuf.conv1_lbuf_vld_o !== 1'b0) begin failures++; $display("FAIL reset_vld vld_o=%b required 0", lbuf.conv1_lbuf_vld_o); end
    checks++;
    if (lbuf.conv1_lbuf_rdy_o !== 1'b1) begin failures++; $display("FAIL reset_rdy rdy_o=%b required 1", lbuf.conv1_lbuf_rdy_o); end
    checks++;
    if (lbuf.conv1_lbuf_a_o !== '0) begin failures++; $display("FAIL reset_a a_o=%h required 0", lbuf.conv1_lbuf_a_o); end
    checks++;
    if (lbuf.conv1_lbuf_b_o !== '0) begin failures++; $display("FAIL reset_b b_o=%h required 0", lbuf.conv1_lbuf_b_o); end
    checks++;
    if (lbuf.conv1_lbuf_frame_done_o !== 1'b0) begin failures++; $display("FAIL reset_done frame_done_o=%b required 0", lbuf.conv1_lbuf_frame_done_o); end
    tick();
    rst_b = 1'b1;
    tick();
  endtask

  task automatic test_pairing();
    for (int k = 0; k < BPR; k++) begin
      send(10 + k);
      checks++;
      if (lbuf.conv1_lbuf_vld_o !== 1'b0) begin failures++; $display("FAIL fill_no_out beat=%0d vld_o=%b required 0", k, lbuf.conv1_lbuf_vld_o); end
    end
    for (int k = 0; k < BPR; k++) begin
      send(100 + k);
      checks++;
      if (lbuf.conv1_lbuf_vld_o !== 1'b1 || lbuf.conv1_lbuf_a_o !== fill(10 + k) || lbuf.conv1_lbuf_b_o !== fill(100 + k)) begin
        failures++;
        $display("FAIL pair beat=%0d vld_o=%b a0=%0d b0=%0d required vld 1 a %0d b %0d", k, lbuf.conv1_lbuf_vld_o,
                 lbuf.conv1_lbuf_a_o[0][0], lbuf.conv1_lbuf_b_o[0][0], 10 + k, 100 + k);
      end
    end
    tick();
    checks++;
    if (lbuf.conv1_lbuf_vld_o !== 1'b0) begin failures++; $display("FAIL pair_drain vld_o=%b required 0", lbuf.conv1_lbuf_vld_o); end
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < BPR; k++) send(20 + k);
    lbuf.conv1_lbuf_rdy_i = 1'b0;
    send(200);
    checks++;
    if (lbuf.conv1_lbuf_vld_o !== 1'b1 || lbuf.conv1_lbuf_a_o !== fill(20) || lbuf.conv1_lbuf_b_o !== fill(200)) begin
      failures++; $display("FAIL bp_first vld_o=%b a0=%0d b0=%0d required 1 20 200", lbuf.conv1_lbuf_vld_o, lbuf.conv1_lbuf_a_o[0][0], lbuf.conv1_lbuf_b_o[0][0]);
    end
    lbuf.conv1_lbuf_pix_i = fill(201);
    lbuf.conv1_lbuf_vld_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (lbuf.conv1_lbuf_rdy_o !== 1'b0 || lbuf.conv1_lbuf_vld_o !== 1'b1 ||
          lbuf.conv1_lbuf_a_o !== fill(20) || lbuf.conv1_lbuf_b_o !== fill(200)) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d rdy_o=%b vld_o=%b a0=%0d b0=%0d required 0 1 20 200", i, lbuf.conv1_lbuf_rdy_o,
                 lbuf.conv1_lbuf_vld_o, lbuf.conv1_lbuf_a_o[0][0], lbuf.conv1_lbuf_b_o[0][0]);
      end
      tick();
    end
    lbuf.conv1_lbuf_rdy_i = 1'b1;
    #1;
    checks++;
    if (lbuf.conv1_lbuf_rdy_o !== 1'b1) begin failures++; $display("FAIL bp_release rdy_o=%b required 1", lbuf.conv1_lbuf_rdy_o); end
    tick();
    lbuf.conv1_lbuf_vld_i = 1'b0;
    checks++;
    if (lbuf.conv1_lbuf_vld_o !== 1'b1 || lbuf.conv1_lbuf_a_o !== fill(21) || lbuf.conv1_lbuf_b_o !== fill(201)) begin
      failures++; $display("FAIL bp_resume vld_o=%b a0=%0d b0=%0d required 1 21 201", lbuf.conv1_lbuf_vld_o, lbuf.conv1_lbuf_a_o[0][0], lbuf.conv1_lbuf_b_o[0][0]);
    end
    for (int k = 2; k < BPR; k++) begin
      send(200 + k);
      checks++;
      if (lbuf.conv1_lbuf_vld_o !== 1'b1 || lbuf.conv1_lbuf_a_o !== fill(20 + k) || lbuf.conv1_lbuf_b_o !== fill(200 + k)) begin
        failures++; $display("FAIL bp_tail beat=%0d a0=%0d b0=%0d required %0d %0d", k, lbuf.conv1_lbuf_a_o[0][0], lbuf.conv1_lbuf_b_o[0][0], 20 + k, 200 + k);
      end
    end
    tick();
    checks++;
    if (lbuf.conv1_lbuf_vld_o !== 1'b0) begin failures++; $display("FAIL bp_drain vld_o=%b required 0", lbuf.conv1_lbuf_vld_o); end
  endtask

  task automatic test_full_frame();
    int outs;
    outs = 0;
    do_reset();
    for (int r = 0; r < NR; r++) begin
      for (int k = 0; k < BPR; k++) begin
        send(r * 16 + k);
        if (lbuf.conv1_lbuf_vld_o === 1'b1) outs++;
        checks++;
        if (r % 2 == 1) begin
          if (lbuf.conv1_lbuf_vld_o !== 1'b1 || lbuf.conv1_lbuf_frame_done_o !== 1'b0 ||
              lbuf.conv1_lbuf_a_o !== fill((r - 1) * 16 + k) || lbuf.conv1_lbuf_b_o !== fill(r * 16 + k)) begin
            failures++;
            $display("FAIL frame_pair row=%0d beat=%0d vld_o=%b done=%b a0=%0d b0=%0d required 1 0 %0d %0d", r, k,
                     lbuf.conv1_lbuf_vld_o, lbuf.conv1_lbuf_frame_done_o, lbuf.conv1_lbuf_a_o[0][0],
                     lbuf.conv1_lbuf_b_o[0][0], (r - 1) * 16 + k, r * 16 + k);
          end
        end else if (lbuf.conv1_lbuf_vld_o !== 1'b0 || lbuf.conv1_lbuf_frame_done_o !== 1'b0) begin
          failures++;
          $display("FAIL frame_fill row=%0d beat=%0d vld_o=%b done=%b required 0 0", r, k, lbuf.conv1_lbuf_vld_o, lbuf.conv1_lbuf_frame_done_o);
        end
      end
    end
    tick();
    checks++;
    if (lbuf.conv1_lbuf_frame_done_o !== 1'b1 || lbuf.conv1_lbuf_vld_o !== 1'b0) begin
      failures++; $display("FAIL frame_done_pulse done=%b vld_o=%b required 1 0", lbuf.conv1_lbuf_frame_done_o, lbuf.conv1_lbuf_vld_o);
    end
    tick();
    checks++;
    if (lbuf.conv1_lbuf_frame_done_o !== 1'b0) begin failures++; $display("FAIL frame_done_single done=%b required 0", lbuf.conv1_lbuf_frame_done_o); end
    checks++;
    if (outs != (NR / 2) * BPR) begin failures++; $display("FAIL frame_out_count got=%0d required %0d", outs, (NR / 2) * BPR); end
    checks++;
    if (dut.row_cnt !== '0) begin failures++; $display("FAIL frame_row_wrap row_cnt=%0d required 0", dut.row_cnt); end
  endtask

  task automatic test_reset_mid_row();
    for (int k = 0; k < BPR; k++) send(30 + k);
    for (int k = 0; k < 3; k++) send(300 + k);
    lbuf.conv1_lbuf_pix_i = fill(303);
    lbuf.conv1_lbuf_vld_i = 1'b1;
    rst_b = 1'b0;
    #1;
    checks++;
    if (lbuf.conv1_lbuf_vld_o !== 1'b0 || lbuf.conv1_lbuf_a_o !== '0) begin
      failures++; $display("FAIL midrst_clear vld_o=%b a0=%0d required 0 0", lbuf.conv1_lbuf_vld_o, lbuf.conv1_lbuf_a_o[0][0]);
    end
    tick();
    lbuf.conv1_lbuf_vld_i = 1'b0;
    rst_b = 1'b1;
    tick();
    for (int k = 0; k < BPR; k++) begin
      send(50 + k);
      checks++;
      if (lbuf.conv1_lbuf_vld_o !== 1'b0) begin failures++; $display("FAIL midrst_fill beat=%0d vld_o=%b required 0", k, lbuf.conv1_lbuf_vld_o); end
    end
    send(500);
    checks++;
    if (lbuf.conv1_lbuf_vld_o !== 1'b1 || lbuf.conv1_lbuf_a_o !== fill(50) || lbuf.conv1_lbuf_b_o !== fill(500)) begin
      failures++; $display("FAIL midrst_pair vld_o=%b a0=%0d b0=%0d required 1 50 500", lbuf.conv1_lbuf_vld_o, lbuf.conv1_lbuf_a_o[0][0], lbuf.conv1_lbuf_b_o[0][0]);
    end
  endtask

  task automatic test_relu();
    pix_t neg_exp;
`ifdef CONV1_LBUF_RELU_EN
    neg_exp = fill(0);
`else
    neg_exp = fill(-5);
`endif
    do_reset();
    send(-5);
    send(7);
    for (int k = 2; k < BPR; k++) send(-5);
    send(-5);
    checks++;
    if (lbuf.conv1_lbuf_a_o !== neg_exp || lbuf.conv1_lbuf_b_o !== neg_exp) begin
      failures++; $display("FAIL relu_neg a0=%h b0=%h required %h", lbuf.conv1_lbuf_a_o[0][0], lbuf.conv1_lbuf_b_o[0][0], neg_exp[0][0]);
    end
    send(3);
    checks++;
    if (lbuf.conv1_lbuf_a_o !== fill(7) || lbuf.conv1_lbuf_b_o !== fill(3)) begin
      failures++; $display("FAIL relu_pos a0=%0d b0=%0d required 7 3", lbuf.conv1_lbuf_a_o[0][0], lbuf.conv1_lbuf_b_o[0][0]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_pairing();
    test_backpressure();
    test_full_frame();
    test_reset_mid_row();
    test_relu();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
